jtag_host: RTL and testbench
============================

JTAG_HOST -- requirements
Module: jtag_host

Interface
REQ-001 SHALL have parameter DATA_W, default 32, max shift length and width of cmd_data/rsp_data.
REQ-002 SHALL have port clk  in  1  single clock; the target TAP samples on the same edge (tck = clk).
REQ-003 SHALL have port trst  in  1  synchronous, active-high reset.
REQ-004 SHALL have port cmd_valid  in  1  command offered.
REQ-005 SHALL have port cmd_ready  out  1  host idle; command accepted when valid && ready.
REQ-006 SHALL have port cmd_op  in  2  00 TAP_RESET, 01 SHIFT_IR, 10 SHIFT_DR, 11 RUN_IDLE.
REQ-007 SHALL have port cmd_len  in  $clog2(DATA_W)  bit count minus 1 (shift), cycle count minus 1 (RUN_IDLE).
REQ-008 SHALL have port cmd_data  in  DATA_W  TDI payload, bit 0 shifted first.
REQ-009 SHALL have port rsp_valid  out  1  one-cycle pulse, command complete.
REQ-010 SHALL have port rsp_data  out  DATA_W  captured TDO, bit 0 = first captured; bits >= length zero.
REQ-011 SHALL have ports tms out 1, tdi out 1, tdo in 1  JTAG pins to target TAP.

Function
REQ-012 tms/tdi SHALL be registered; the value driven in cycle k is sampled by the TAP at the end of cycle k.
REQ-013 FSM states SHALL be: RST_SEQ, IDLE, SEL_DR, SEL_IR, CAPTURE, SHIFT, EXIT1, UPDATE, RUN.
REQ-014 IDLE SHALL drive tms=0, tdi=0, cmd_ready=1; every other state SHALL drive cmd_ready=0.
REQ-015 SHIFT_DR SHALL drive tms 1 (SEL_DR), 0 (CAPTURE), n shift cycles of 0 with 1 on the last, 1 (EXIT1), 0 (UPDATE): n+4 cycles.
REQ-016 SHIFT_IR SHALL insert SEL_IR (tms=1) after SEL_DR: n+5 cycles.
REQ-017 tdi SHALL carry cmd_data[i] in shift cycle i and 0 in all other cycles.
REQ-018 tdo SHALL be sampled at the end of every SHIFT cycle into rsp_data bit i.
REQ-019 TAP_RESET SHALL drive tms=1 for 5 cycles then tms=0 for 1 cycle; RUN_IDLE SHALL drive tms=0 for cmd_len+1 cycles.
REQ-020 rsp_valid SHALL pulse in the cycle after the final drive cycle, with cmd_ready=1 in that same cycle; rsp_data SHALL be 0 for TAP_RESET and RUN_IDLE and SHALL hold until the next accept.
REQ-021 cmd_len=0 SHALL give a single shift cycle with tms=1; cmd_len=DATA_W-1 SHALL shift DATA_W bits.
REQ-022 cmd_valid while cmd_ready=0 SHALL be ignored with no queuing; back-to-back commands SHALL have no extra gap cycle.

Reset
REQ-023 trst SHALL clear rsp_valid, rsp_data, tdi and cmd_ready to 0.
REQ-024 trst SHALL enter RST_SEQ, and on release the FSM SHALL perform the TAP_RESET sequence (5x tms=1, then tms=0) before IDLE.
REQ-025 trst mid-command SHALL abort it with no rsp_valid.

Configuration
REQ-026 Macro JTAG_HOST_CAPTURE_EN defined SHALL enable TDO capture per REQ-018.
REQ-027 Macro JTAG_HOST_CAPTURE_EN undefined SHALL omit the capture register, ignore tdo and tie rsp_data to 0; timing SHALL be unchanged.

Structure
REQ-028 Package jtag_host_pkg SHALL hold the op encodings, the FSM state enum and TLR_CYCLES=5.
REQ-029 Sub-module jtag_host_shreg SHALL implement the DATA_W shift register: parallel load, tdi bit out, tdo bit in, bit counter.

Verification
REQ-030 Scenario: release trst -> tms 1,1,1,1,1,0; cmd_ready rises next cycle; no rsp_valid.
REQ-031 Scenario: SHIFT_DR, len=7, data 0xA5, bench DR preloaded 0x3C -> tms 1,0,0,0,0,0,0,0,0,1,1,0; tdi 1,0,1,0,0,1,0,1 in shift cycles; rsp_data=0x3C; DR=0xA5.
REQ-032 Scenario: SHIFT_IR, len=0, data 1 -> tms 1,1,0,1,1,0 (6 cycles); tdi=1 only in the shift cycle; rsp_valid on cycle 7.
REQ-033 Scenario: RUN_IDLE, len=9 -> 10 cycles tms=0, then rsp_valid with rsp_data=0.
REQ-034 Scenario: trst asserted in shift cycle 3 of a SHIFT_DR len=15 -> no rsp_valid; full reset sequence follows release.
REQ-035 Scenario: cmd_valid held across two SHIFT_DR commands -> second accepted in the rsp_valid cycle of the first; CAPTURE_EN undefined run gives rsp_data=0.

Source files
------------

// File: rtl/jtag_host_pkg.sv
// Shared definitions for the JTAG host: command opcodes, FSM states and the
// Test-Logic-Reset walk length.
package jtag_host_pkg;

    typedef enum logic [1:0] {
        OP_TAP_RESET = 2'b00,
        OP_SHIFT_IR  = 2'b01,
        OP_SHIFT_DR  = 2'b10,
        OP_RUN_IDLE  = 2'b11
    } op_t;

    typedef enum logic [3:0] {
        RST_SEQ,
        IDLE,
        SEL_DR,
        SEL_IR,
        CAPTURE,
        SHIFT,
        EXIT1,
        UPDATE,
        RUN
    } state_t;

    localparam int TLR_CYCLES = 5;

    // TMS level for the cycle spent in state s.
    // rst_high is high for the first TLR_CYCLES cycles of RST_SEQ.
    function automatic logic state_tms(input state_t s, input logic rst_high,
                                       input logic shift_last);
        case (s)
            RST_SEQ:              return rst_high;
            SEL_DR, SEL_IR, EXIT1: return 1'b1;
            SHIFT:                return shift_last;
            default:              return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/jtag_host_shreg.sv
// DATA_W shift register for the JTAG host: parallel load, LSB-first TDI bit,
// bit counter and optional TDO capture (enabled by JTAG_HOST_CAPTURE_EN).
module jtag_host_shreg
    import jtag_host_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int LEN_W  = $clog2(DATA_W)
) (
    input  logic              clk,
    input  logic              trst,
    input  logic              load,
    input  logic              shift,
    input  logic [DATA_W-1:0] load_data,
    input  logic [LEN_W-1:0]  load_len,
    input  logic              tdo,
    output logic [LEN_W-1:0]  len,
    output logic              last,
    output logic              next_tdi,
    output logic              next_last,
    output logic [DATA_W-1:0] cap_data
);

    logic [DATA_W-1:0] sr;
    logic [LEN_W-1:0]  bit_cnt;
    logic [LEN_W-1:0]  bit_cnt_inc;

    assign bit_cnt_inc = bit_cnt + LEN_W'(1);

    always_ff @(posedge clk) begin
        if (trst) begin
            sr      <= '0;
            len     <= '0;
            bit_cnt <= '0;
        end else if (load) begin
            sr      <= load_data;
            len     <= load_len;
            bit_cnt <= '0;
        end else if (shift) begin
            sr      <= {1'b0, sr[DATA_W-1:1]};
            bit_cnt <= bit_cnt_inc;
        end
    end

    // next_* describe the shift cycle that follows the current edge, so the
    // host can register tms/tdi one cycle ahead.
    assign last      = (bit_cnt == len);
    assign next_tdi  = shift ? sr[1] : sr[0];
    assign next_last = shift ? (bit_cnt_inc == len) : (len == '0);

`ifdef JTAG_HOST_CAPTURE_EN
    logic [DATA_W-1:0] cap;

    always_ff @(posedge clk) begin
        if (trst) begin
            cap <= '0;
        end else if (load) begin
            cap <= '0;
        end else if (shift) begin
            cap[bit_cnt] <= tdo;
        end
    end

    assign cap_data = cap;
`else
    logic unused_tdo;
    assign unused_tdo = tdo;
    assign cap_data   = '0;
`endif

endmodule

// File: rtl/jtag_host.sv
// JTAG host: runs one TAP command at a time (reset walk, IR/DR shift, idle
// cycles) on tms/tdi with tck = clk. TDO capture gated by JTAG_HOST_CAPTURE_EN.
module jtag_host
    import jtag_host_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic                      clk,
    input  logic                      trst,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [1:0]                cmd_op,
    input  logic [$clog2(DATA_W)-1:0] cmd_len,
    input  logic [DATA_W-1:0]         cmd_data,
    output logic                      rsp_valid,
    output logic [DATA_W-1:0]         rsp_data,
    output logic                      tms,
    output logic                      tdi,
    input  logic                      tdo,
    output logic [3:0]                dbg_state
);

    localparam int LEN_W = $clog2(DATA_W);
    localparam int CNT_W = (LEN_W > 3) ? LEN_W : 3;

    state_t             state, state_n;
    logic [CNT_W-1:0]   cyc_cnt, cyc_n;
    op_t                op_q;
    logic               active;
    logic               load, shift_en, done;
    logic               tms_n, tdi_n;
    logic [LEN_W-1:0]   len;
    logic               last, next_tdi, next_last;

    // Handshake: a command is taken on the rising edge where cmd_valid && cmd_ready;
    // cmd_ready is high only in IDLE and nothing offered outside IDLE is remembered.
    assign cmd_ready = (state == IDLE);
    assign shift_en  = (state == SHIFT);
    assign dbg_state = state;

    jtag_host_shreg #(
        .DATA_W (DATA_W),
        .LEN_W  (LEN_W)
    ) u_shreg (
        .clk       (clk),
        .trst      (trst),
        .load      (load),
        .shift     (shift_en),
        .load_data (cmd_data),
        .load_len  (cmd_len),
        .tdo       (tdo),
        .len       (len),
        .last      (last),
        .next_tdi  (next_tdi),
        .next_last (next_last),
        .cap_data  (rsp_data)
    );

    always_comb begin
        state_n = state;
        cyc_n   = cyc_cnt;
        load    = 1'b0;
        case (state)
            RST_SEQ: begin
                if (cyc_cnt == CNT_W'(TLR_CYCLES)) state_n = IDLE;
                else                                 cyc_n   = cyc_cnt + CNT_W'(1);
            end
            IDLE: begin
                if (cmd_valid) begin
                    load  = 1'b1;
                    cyc_n = '0;
                    case (op_t'(cmd_op))
                        OP_TAP_RESET: state_n = RST_SEQ;
                        OP_RUN_IDLE:  state_n = RUN;
                        default:      state_n = SEL_DR;
                    endcase
                end
            end
            SEL_DR:  state_n = (op_q == OP_SHIFT_IR) ? SEL_IR : CAPTURE;
            SEL_IR:  state_n = CAPTURE;
            CAPTURE: state_n = SHIFT;
            SHIFT:   if (last) state_n = EXIT1;
            EXIT1:   state_n = UPDATE;
            UPDATE:  state_n = IDLE;
            RUN: begin
                if (cyc_cnt == CNT_W'(len)) state_n = IDLE;
                else                          cyc_n   = cyc_cnt + CNT_W'(1);
            end
            default: state_n = RST_SEQ;
        endcase

        // Pins are registered from the next state so they line up with it.
        tms_n = state_tms(state_n, cyc_n < CNT_W'(TLR_CYCLES), next_last);
        tdi_n = (state_n == SHIFT) && next_tdi;
        done  = (state != IDLE) && (state_n == IDLE) && active;
    end

    always_ff @(posedge clk) begin
        if (trst) begin
            state     <= RST_SEQ;
            cyc_cnt   <= '0;
            op_q      <= OP_TAP_RESET;
            active    <= 1'b0;
            tms       <= 1'b1;
            tdi       <= 1'b0;
            rsp_valid <= 1'b0;
        end else begin
            state     <= state_n;
            cyc_cnt   <= cyc_n;
            tms       <= tms_n;
            tdi       <= tdi_n;
            rsp_valid <= done;
            if (load) begin
                op_q   <= op_t'(cmd_op);
                active <= 1'b1;
            end else if (done) begin
                active <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_jtag_host.sv
// Self-checking bench for jtag_host: per-cycle pin/response model driven by a
// command-level expectation queue, directed scenarios and random traffic.
module tb_jtag_host;

    localparam int DATA_W = 32;
    localparam int LEN_W  = 5;

    logic              clk = 1'b0;
    logic              trst;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [LEN_W-1:0]  cmd_len;
    logic [DATA_W-1:0] cmd_data;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;
    logic              tms, tdi;
    logic              tdo = 1'b0;
    logic [3:0]        dbg_state;

    int checks = 0;
    int errors = 0;

    // Expected per-cycle steps: {tms, tdi, is_shift, shift_index[4:0]}
    logic [7:0]  exp_q[$];
    logic        pending   = 1'b0;
    logic        rst_cycle = 1'b1;
    logic [31:0] exp_rd    = '0;
    logic [31:0] next_rd   = '0;
    logic [31:0] cur_pat   = '0;
    logic [31:0] tdo_pat   = '0;
    logic [31:0] cap_tdi   = '0;
    logic [63:0] log_tms   = '0;
    logic [63:0] log_tdi   = '0;
    int          log_n     = 0;
    logic        log_en    = 1'b0;
    int          rv_count  = 0;

    jtag_host #(.DATA_W(DATA_W)) dut (
        .clk       (clk),
        .trst      (trst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_len   (cmd_len),
        .cmd_data  (cmd_data),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .tms       (tms),
        .tdi       (tdi),
        .tdo       (tdo),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void push_cmd(input logic [1:0] op, input logic [4:0] len,
                                     input logic [31:0] data);
        int n;
        n = int'(len) + 1;
        case (op)
            2'b00: begin
                for (int i = 0; i < 5; i++) exp_q.push_back(8'h80);
                exp_q.push_back(8'h00);
            end
            2'b11: for (int i = 0; i < n; i++) exp_q.push_back(8'h00);
            default: begin
                exp_q.push_back(8'h80);
                if (op == 2'b01) exp_q.push_back(8'h80);
                exp_q.push_back(8'h00);
                for (int i = 0; i < n; i++)
                    exp_q.push_back({(i == n - 1) ? 1'b1 : 1'b0, data[i], 1'b1, 5'(i)});
                exp_q.push_back(8'h80);
                exp_q.push_back(8'h00);
            end
        endcase
    endfunction

    function automatic logic [31:0] exp_capture(input logic [1:0] op, input logic [4:0] len,
                                                input logic [31:0] pat);
        logic [31:0] mask;
        mask = (len == 5'd31) ? 32'hFFFF_FFFF : ((32'd1 << (int'(len) + 1)) - 32'd1);
`ifdef JTAG_HOST_CAPTURE_EN
        return (op == 2'b01 || op == 2'b10) ? (pat & mask) : 32'd0;
`else
        return (op == 2'b01 || op == 2'b10) ? (pat & mask & 32'd0) : 32'd0;
`endif
    endfunction

    // Compare process and target-side TDO source, one step per cycle.
    initial begin : cmp_proc
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (log_en && !cmd_ready) begin
                log_tms = {log_tms[62:0], tms};
                log_tdi = {log_tdi[62:0], tdi};
                log_n++;
            end
            if (rsp_valid === 1'b1) rv_count++;
            if (rst_cycle) begin
                chk("rst_tms", tms, 1);
                chk("rst_tdi", tdi, 0);
                chk("rst_ready", cmd_ready, 0);
                chk("rst_rsp_valid", rsp_valid, 0);
                chk("rst_rsp_data", rsp_data, 0);
                exp_q.delete();
                if (!trst) for (int i = 0; i < 5; i++) exp_q.push_back((i < 4) ? 8'h80 : 8'h00);
                tdo = 1'($urandom);
            end else if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("busy_tms", tms, e[7]);
                chk("busy_tdi", tdi, e[6]);
                chk("busy_ready", cmd_ready, 0);
                chk("busy_rsp_valid", rsp_valid, 0);
                if (e[5]) begin
                    tdo = cur_pat[e[4:0]];
                    cap_tdi[e[4:0]] = tdi;
                end else begin
                    tdo = 1'($urandom);
                end
            end else begin
                if (pending) exp_rd = next_rd;
                chk("idle_tms", tms, 0);
                chk("idle_tdi", tdi, 0);
                chk("idle_ready", cmd_ready, 1);
                chk("rsp_valid", rsp_valid, pending);
                chk("rsp_data", rsp_data, exp_rd);
                pending = 1'b0;
                if (cmd_valid) begin
                    push_cmd(cmd_op, cmd_len, cmd_data);
                    pending = 1'b1;
                    cur_pat = tdo_pat;
                    cap_tdi = '0;
                    next_rd = exp_capture(cmd_op, cmd_len, tdo_pat);
                end
                tdo = 1'($urandom);
            end
            if (trst) begin
                exp_q.delete();
                pending = 1'b0;
                exp_rd  = '0;
            end
            rst_cycle = trst;
        end
    end

    task automatic clear_log();
        log_tms = '0;
        log_tdi = '0;
        log_n   = 0;
    endtask

    task automatic wait_ready(input int budget, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!cmd_ready && n < budget);
        chk("ready_timeout", cmd_ready, 1);
    endtask

    task automatic wait_rsp(input int budget, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rsp_valid && n < budget);
        chk("rsp_timeout", rsp_valid, 1);
    endtask

    task automatic send(input logic [1:0] op, input logic [4:0] len,
                        input logic [31:0] data, input logic [31:0] pat);
        int n;
        @(posedge clk);
        #1;
        cmd_op    = op;
        cmd_len   = len;
        cmd_data  = data;
        tdo_pat   = pat;
        cmd_valid = 1'b1;
        wait_ready(200, n);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    initial begin : main_proc
        int n;
        int rv_before;
        int rst_hold;
        logic [31:0] pat1;
        trst      = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_len   = '0;
        cmd_data  = '0;
        rst_hold  = 0;

        // Reset release: five tms=1 then one tms=0, then ready.
        repeat (3) @(posedge clk);
        #1;
        trst = 1'b0;
        clear_log();
        log_en = 1'b1;
        wait_ready(50, n);
        log_en = 1'b0;
        chk("rst_seq_len", log_n, 6);
        chk("rst_seq_tms", log_tms[5:0], 6'b111110);
        chk("rst_no_rsp", rv_count, 0);

        // SHIFT_DR len 7, data 0xA5, target DR 0x3C.
        clear_log();
        log_en = 1'b1;
        send(2'b10, 5'd7, 32'h0000_00A5, 32'h0000_003C);
        wait_rsp(100, n);
        log_en = 1'b0;
        chk("dr_len", log_n, 12);
        chk("dr_tms", log_tms[11:0], 12'b100000000110);
        chk("dr_tdi", log_tdi[11:0], 12'b001010010100);
        chk("dr_target_dr", cap_tdi[7:0], 8'hA5);
`ifdef JTAG_HOST_CAPTURE_EN
        chk("dr_rsp_data", rsp_data, 32'h0000_003C);
`else
        chk("dr_rsp_data", rsp_data, 32'h0);
`endif

        // SHIFT_IR len 0, data 1: response on the 7th cycle after accept.
        clear_log();
        log_en = 1'b1;
        send(2'b01, 5'd0, 32'h0000_0001, 32'hFFFF_FFFF);
        wait_rsp(100, n);
        log_en = 1'b0;
        chk("ir_rsp_cycle", n, 7);
        chk("ir_tms", log_tms[5:0], 6'b110110);
        chk("ir_tdi", log_tdi[5:0], 6'b000100);
`ifdef JTAG_HOST_CAPTURE_EN
        chk("ir_rsp_data", rsp_data, 32'h0000_0001);
`else
        chk("ir_rsp_data", rsp_data, 32'h0);
`endif

        // RUN_IDLE len 9: ten tms=0 cycles.
        clear_log();
        log_en = 1'b1;
        send(2'b11, 5'd9, 32'hDEAD_BEEF, 32'hFFFF_FFFF);
        wait_rsp(100, n);
        log_en = 1'b0;
        chk("run_rsp_cycle", n, 11);
        chk("run_len", log_n, 10);
        chk("run_tms", log_tms[9:0], 10'b0);
        chk("run_rsp_data", rsp_data, 32'h0);

        // trst in shift cycle 3 of SHIFT_DR len 15.
        rv_before = rv_count;
        send(2'b10, 5'd15, $urandom, $urandom);
        repeat (5) @(posedge clk);
        #1;
        trst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        trst = 1'b0;
        clear_log();
        log_en = 1'b1;
        wait_ready(50, n);
        log_en = 1'b0;
        chk("abort_no_rsp", rv_count, rv_before);
        chk("abort_rst_len", log_n, 6);
        chk("abort_rst_tms", log_tms[5:0], 6'b111110);

        // cmd_valid held across two SHIFT_DR commands.
        pat1 = $urandom;
        @(posedge clk);
        #1;
        cmd_op    = 2'b10;
        cmd_len   = 5'd3;
        cmd_data  = $urandom;
        tdo_pat   = pat1;
        cmd_valid = 1'b1;
        wait_ready(50, n);
        @(posedge clk);
        #1;
        cmd_len  = 5'd5;
        cmd_data = $urandom;
        tdo_pat  = $urandom;
        wait_ready(50, n);
        chk("b2b_gap", n, 9);
        chk("b2b_rsp_valid", rsp_valid, 1);
`ifdef JTAG_HOST_CAPTURE_EN
        chk("b2b_rsp_data", rsp_data, {28'h0, pat1[3:0]});
`else
        chk("b2b_rsp_data", rsp_data, 32'h0);
`endif
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        wait_rsp(100, n);

        // Random traffic, including commands offered while busy and short trst pulses.
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #1;
            if (trst) begin
                if (rst_hold == 0) trst = 1'b0;
                else rst_hold--;
            end else if ($urandom_range(0, 199) == 0) begin
                trst     = 1'b1;
                rst_hold = $urandom_range(0, 2);
            end
            cmd_valid = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1) == 1) begin
                cmd_op   = 2'($urandom_range(0, 3));
                cmd_len  = ($urandom_range(0, 3) == 0) ?
                           (($urandom_range(0, 1) == 1) ? 5'd31 : 5'd0) :
                           5'($urandom_range(0, 31));
                cmd_data = $urandom;
                tdo_pat  = $urandom;
            end
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        trst      = 1'b0;
        wait_ready(200, n);
        repeat (3) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
